// File: rtl/mmio_bus_fabric.sv
// Single-master MMIO fabric: decodes a 3-bit slave index from the address, runs a
// chip-select handshake with wait/timeout, and keeps a sticky first-fault record.
module mmio_bus_fabric #(
  parameter int unsigned     NSLV     = 4,
  parameter int unsigned     DW       = 32,
  parameter int unsigned     AW       = 32,
  parameter int unsigned     SEL_LSB  = 12,
  parameter int unsigned     TIMEOUT  = 16,
  parameter logic [DW-1:0]   ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_req,
  input  logic               m_we,
  input  logic [AW-1:0]      m_addr,
  input  logic [DW-1:0]      m_wdata,
  output logic [DW-1:0]      m_rdata,
  output logic               m_ack,
  output logic               m_err,
  output logic [NSLV-1:0]    s_cs_n,
  output logic               s_we,
  output logic [11:0]        s_addr,
  output logic [DW-1:0]      s_wdata,
  input  logic [NSLV*DW-1:0] s_rdata,
  input  logic [NSLV-1:0]    s_ready,
  output logic               irq_err,
  output logic [AW-1:0]      err_addr,
  input  logic               err_clr
);

  localparam int unsigned CW = 8;
  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q,    state_d;
  logic            we_q,       we_d;
  logic [AW-1:0]   addr_q,     addr_d;
  logic [DW-1:0]   wdata_q,    wdata_d;
  logic [IW-1:0]   idx_q,      idx_d;
  logic [NSLV-1:0] cs_n_q,     cs_n_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            ack_q,      ack_d;
  logic            merr_q,     merr_d;
  logic [DW-1:0]   rdata_q,    rdata_d;
  logic            irq_q,      irq_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;

  logic            sel_rdy;
  logic [DW-1:0]   sel_rdata;
  logic [IW-1:0]   idx_in;
  logic            new_err;
  logic [AW-1:0]   fault_addr;

  // Next-state and datapath for the transfer FSM and the sticky error record
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    cs_n_d     = cs_n_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    merr_d     = 1'b0;
    rdata_d    = rdata_q;
    irq_d      = irq_q;
    err_addr_d = err_addr_q;
    new_err    = 1'b0;
    fault_addr = addr_q;
    idx_in     = m_addr[SEL_LSB +: IW];

    // Only the selected slave's ready and read data are looked at
    sel_rdy   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        sel_rdy   = s_ready[i];
        sel_rdata = s_rdata[i*DW +: DW];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          idx_d   = idx_in;
          if (32'(idx_in) < NSLV) begin
            for (int unsigned i = 0; i < NSLV; i++) begin
              cs_n_d[i] = (idx_in != IW'(i));
            end
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            state_d    = RESP;
            ack_d      = 1'b1;
            merr_d     = 1'b1;
            new_err    = 1'b1;
            fault_addr = m_addr;
            if (!m_we) rdata_d = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        if (sel_rdy) begin
          cs_n_d  = '1;
          state_d = RESP;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = sel_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cs_n_d  = '1;
          state_d = RESP;
          ack_d   = 1'b1;
          merr_d  = 1'b1;
          new_err = 1'b1;
          if (!we_q) rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = '1;
      end
    endcase

    // A new fault outranks a same-cycle clear; otherwise the first fault is kept
    if (new_err) begin
      irq_d = 1'b1;
      if (!irq_q || err_clr) err_addr_d = fault_addr;
    end else if (err_clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      cs_n_q     <= '1;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      merr_q     <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      cs_n_q     <= cs_n_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      merr_q     <= merr_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_rdata  = rdata_q;
  assign m_ack    = ack_q;
  assign m_err    = merr_q;
  assign s_cs_n   = cs_n_q;
  assign s_we     = we_q;
  assign s_addr   = addr_q[11:0];
  assign s_wdata  = wdata_q;
  assign irq_err  = irq_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: directed scenarios then random transfers
// scored against a transaction-level model of latency, selects, data and error record.
module tb_mmio_bus_fabric;

  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_req, m_we;
  logic [31:0]  m_addr, m_wdata, m_rdata;
  logic         m_ack, m_err;
  logic [3:0]   s_cs_n;
  logic         s_we;
  logic [11:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic         irq_err;
  logic [31:0]  err_addr;
  logic         err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_rdata;
  logic        exp_irq;
  logic [31:0] exp_eaddr;

  mmio_bus_fabric dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_cs_n(s_cs_n), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .irq_err(irq_err),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One master transfer; waits >= 16 means the slave never answers
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input int waits, input logic clr);
    int          idx;
    bit          mapped, err, done;
    int          lcs, ackc;
    logic [31:0] sdat;
    logic [3:0]  exp_cs, mask;
    idx    = int'(addr[14:12]);
    mapped = (idx < 4);
    lcs    = !mapped ? 0 : ((waits >= 16) ? 16 : waits + 1);
    ackc   = lcs + 1;
    err    = !mapped || (waits >= 16);
    sdat   = $urandom;
    mask   = mapped ? ~(4'b0001 << idx) : 4'hF;
    for (int i = 0; i < 4; i++)
      s_rdata[i*32 +: 32] = (mapped && i == idx) ? sdat : $urandom;
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wd;
    s_ready = 4'($urandom) & mask;
    err_clr = clr && (ackc == 1);
    done    = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
      err_clr = 1'b0;
      exp_cs = (mapped && c <= lcs) ? mask : 4'hF;
      check("cs_n", 64'(s_cs_n), 64'(exp_cs));
      if (c == 1 && mapped) begin
        check("s_addr", 64'(s_addr), 64'(addr[11:0]));
        check("s_we", 64'(s_we), 64'(we));
        check("s_wdata", 64'(s_wdata), 64'(wd));
      end
      if (c == ackc) begin
        if (err) begin
          if (!we) exp_rdata = ERRD;
          if (!exp_irq || clr) exp_eaddr = addr;
          exp_irq = 1'b1;
        end else begin
          if (!we) exp_rdata = sdat;
          if (clr) exp_irq = 1'b0;
        end
        check("ack", 64'(m_ack), 64'd1);
        check("m_err", 64'(m_err), 64'(err));
        check("m_rdata", 64'(m_rdata), 64'(exp_rdata));
        check("irq_err", 64'(irq_err), 64'(exp_irq));
        check("err_addr", 64'(err_addr), 64'(exp_eaddr));
        m_req = 1'b0;
        done  = 1'b1;
      end else begin
        check("ack_early", 64'(m_ack), 64'd0);
      end
      s_ready = 4'($urandom) & mask;
      if (mapped && (c - 1) >= waits) s_ready[idx] = 1'b1;
      err_clr = clr && (c == ackc - 1);
    end
    check("ack_seen", 64'(done), 64'd1);
    s_ready = 4'h0;
    m_req   = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", 64'(m_ack), 64'd0);
  endtask

  task automatic clear_irq();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_irq = 1'b0;
    check("clr_irq", 64'(irq_err), 64'd0);
    check("clr_eaddr", 64'(err_addr), 64'(exp_eaddr));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"}, 64'(s_cs_n), 64'hF);
    check({tag, "_ack"}, 64'(m_ack), 64'd0);
    check({tag, "_err"}, 64'(m_err), 64'd0);
    check({tag, "_rdata"}, 64'(m_rdata), 64'd0);
    check({tag, "_irq"}, 64'(irq_err), 64'd0);
    check({tag, "_eaddr"}, 64'(err_addr), 64'd0);
    check({tag, "_swe"}, 64'(s_we), 64'd0);
    check({tag, "_saddr"}, 64'(s_addr), 64'd0);
    check({tag, "_swdata"}, 64'(s_wdata), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          r, w;
    reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ready = '0; err_clr = 1'b0;
    exp_rdata = '0; exp_irq = 1'b0; exp_eaddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read from slave 1
    xfer(1'b0, 32'h0000_1004, 32'h0, 0, 1'b0);
    // Write to slave 2 with three wait states
    xfer(1'b1, 32'h0000_2010, 32'hA5A5_A5A5, 3, 1'b0);
    // Unmapped read
    xfer(1'b0, 32'h0000_5000, 32'h0, 0, 1'b0);
    clear_irq();
    // Timeouts: first fault sticks, clear drops irq
    xfer(1'b0, 32'h0000_0040, 32'h0, 100, 1'b0);
    xfer(1'b0, 32'h0000_3000, 32'h0, 100, 1'b0);
    clear_irq();
    // Error write leaves read data alone; clear coinciding with a fault
    xfer(1'b1, 32'h0000_7008, 32'h1111_2222, 0, 1'b0);
    xfer(1'b0, 32'h0000_6ABC, 32'h0, 0, 1'b1);
    clear_irq();
    // Ready arriving on the last cycle before timeout still completes cleanly
    xfer(1'b0, 32'h0000_0FFC, 32'h0, 15, 1'b0);

    // Reset in the middle of an access
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_2020; s_ready = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_cs", 64'(s_cs_n), 64'hB);
    reset = 1'b1;
    #1;
    check_reset_vals("arst");
    m_req = 1'b0;
    @(posedge clk); #1;
    check("arst_noack", 64'(m_ack), 64'd0);
    reset = 1'b0;
    exp_rdata = '0; exp_irq = 1'b0; exp_eaddr = '0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h0000_2020, 32'h0, 1, 1'b0);

    // Random transfers
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      a[14:12] = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      w = (r == 7) ? 100 : r;
      xfer(1'($urandom), a, $urandom, w, ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
